// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared types and field positions for the FC layer sequencer
package fc_seq_pkg;

    typedef enum logic [1:0] {
        FC_IDLE      = 2'd0,
        FC_ISSUE     = 2'd1,
        FC_WAIT_DONE = 2'd2,
        FC_EMIT      = 2'd3
    } fc_state_e;

    localparam int FC_DESC_W = 160;

    localparam int FC_DIMS_IN_MSB  = 31;
    localparam int FC_DIMS_IN_LSB  = 16;
    localparam int FC_DIMS_OUT_MSB = 15;
    localparam int FC_DIMS_OUT_LSB = 0;

    typedef struct packed {
        logic [31:0] input_ptr;
        logic [31:0] weights_ptr;
        logic [31:0] bias_ptr;
        logic [31:0] output_ptr;
        logic [15:0] input_size;
        logic [15:0] output_size;
    } fc_desc_t;

    function automatic logic [31:0] pack_dims(input logic [15:0] in_size,
                                              input logic [15:0] out_size);
        logic [31:0] d;
        d = '0;
        d[FC_DIMS_IN_MSB:FC_DIMS_IN_LSB]   = in_size;
        d[FC_DIMS_OUT_MSB:FC_DIMS_OUT_LSB] = out_size;
        return d;
    endfunction

endpackage

// File: rtl/fc_desc_fifo.sv
// rtl/fc_desc_fifo.sv - synchronous descriptor FIFO with wrapping pointers
module fc_desc_fifo
    import fc_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  fc_desc_t                 wr_data,
    input  logic                     rd_en,
    output fc_desc_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fc_desc_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - queues FC layer descriptors and issues them to the FC unit
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_input_ptr,
    input  logic [31:0] desc_weights_ptr,
    input  logic [31:0] desc_bias_ptr,
    input  logic [31:0] desc_output_ptr,
    input  logic [15:0] desc_input_size,
    input  logic [15:0] desc_output_size,
    output logic        fc_start,
    output logic [31:0] fc_input_ptr,
    output logic [31:0] fc_weights_ptr,
    output logic [31:0] fc_bias_ptr,
    output logic [31:0] fc_output_ptr,
    output logic [31:0] fc_dims,
    input  logic        fc_ready,
    input  logic        fc_done,
    input  logic [31:0] fc_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_error,
    output logic        busy,
    output logic [15:0] layers_done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    fc_state_e        state;
    fc_desc_t         push_desc;
    fc_desc_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             push;
    logic             pop;
    logic [TMO_W-1:0] tmo_cnt;

    assign push_desc = '{input_ptr:   desc_input_ptr,
                         weights_ptr: desc_weights_ptr,
                         bias_ptr:    desc_bias_ptr,
                         output_ptr:  desc_output_ptr,
                         input_size:  desc_input_size,
                         output_size: desc_output_size};

    // The entry stays in the FIFO until its result is accepted, so busy covers it.
    assign pop        = (state == FC_EMIT) && res_ready;
    assign desc_ready = !fifo_full || pop;
    assign push       = desc_valid && desc_ready;

    assign fc_start  = (state == FC_ISSUE);
    assign res_valid = (state == FC_EMIT);
    assign busy      = (fifo_count != '0) || (state != FC_IDLE);

    fc_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_desc),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FC_IDLE;
            fc_input_ptr   <= '0;
            fc_weights_ptr <= '0;
            fc_bias_ptr    <= '0;
            fc_output_ptr  <= '0;
            fc_dims        <= '0;
            res_data       <= '0;
            res_error      <= 1'b0;
            layers_done    <= '0;
            tmo_cnt        <= '0;
        end else begin
            case (state)
                FC_IDLE: begin
                    if (!fifo_empty) begin
                        fc_input_ptr   <= head.input_ptr;
                        fc_weights_ptr <= head.weights_ptr;
                        fc_bias_ptr    <= head.bias_ptr;
                        fc_output_ptr  <= head.output_ptr;
                        fc_dims        <= pack_dims(head.input_size, head.output_size);
                        if (head.input_size == '0 || head.output_size == '0) begin
                            res_data  <= '0;
                            res_error <= 1'b1;
                            state     <= FC_EMIT;
                        end else if (fc_ready) begin
                            state <= FC_ISSUE;
                        end
                    end
                end
                FC_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= FC_WAIT_DONE;
                end
                FC_WAIT_DONE: begin
                    // done is checked first so it wins over a coincident timeout
                    if (fc_done) begin
                        res_data  <= fc_result;
                        res_error <= 1'b0;
                        state     <= FC_EMIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_data  <= '0;
                        res_error <= 1'b1;
                        state     <= FC_EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                FC_EMIT: begin
                    if (res_ready) begin
                        layers_done <= layers_done + 16'd1;
                        state       <= FC_IDLE;
                    end
                end
                default: state <= FC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - scoreboard bench for fc_layer_sequencer
module tb_fc_layer_sequencer;

    localparam int DEPTH      = 4;
    localparam int TMO        = 20;
    localparam int RESP_DELAY = 10;

    typedef struct packed {
        logic [31:0] ip;
        logic [31:0] wp;
        logic [31:0] bp;
        logic [31:0] op;
        logic [31:0] dims;
    } start_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_input_ptr = '0;
    logic [31:0] desc_weights_ptr = '0;
    logic [31:0] desc_bias_ptr = '0;
    logic [31:0] desc_output_ptr = '0;
    logic [15:0] desc_input_size = '0;
    logic [15:0] desc_output_size = '0;
    logic        fc_start;
    logic [31:0] fc_input_ptr;
    logic [31:0] fc_weights_ptr;
    logic [31:0] fc_bias_ptr;
    logic [31:0] fc_output_ptr;
    logic [31:0] fc_dims;
    logic        fc_ready = 1'b1;
    logic        fc_done;
    logic [31:0] fc_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_error;
    logic        busy;
    logic [15:0] layers_done;

    logic        done_model = 1'b0;
    logic        done_inject = 1'b0;
    assign fc_done = done_model | done_inject;

    fc_layer_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_input_ptr   (desc_input_ptr),
        .desc_weights_ptr (desc_weights_ptr),
        .desc_bias_ptr    (desc_bias_ptr),
        .desc_output_ptr  (desc_output_ptr),
        .desc_input_size  (desc_input_size),
        .desc_output_size (desc_output_size),
        .fc_start         (fc_start),
        .fc_input_ptr     (fc_input_ptr),
        .fc_weights_ptr   (fc_weights_ptr),
        .fc_bias_ptr      (fc_bias_ptr),
        .fc_output_ptr    (fc_output_ptr),
        .fc_dims          (fc_dims),
        .fc_ready         (fc_ready),
        .fc_done          (fc_done),
        .fc_result        (fc_result),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_error        (res_error),
        .busy             (busy),
        .layers_done      (layers_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_starts = 0;
    int          n_results = 0;
    int          last_start_cyc = 0;
    int          last_rise_cyc = 0;
    int          push_cyc = 0;
    logic [15:0] exp_layers = '0;
    logic        prev_rv = 1'b0;
    bit          resp_en = 1'b1;
    int          resp_cnt = 0;
    start_t      start_q[$];
    res_t        res_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_result(input logic [31:0] ip);
        return (ip == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, ip[15:0]};
    endfunction

    // FC unit model: done RESP_DELAY cycles after the start pulse
    always @(posedge clk) begin
        #1;
        done_model = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    done_model = 1'b1;
                    fc_result  = exp_result(fc_input_ptr);
                end
            end
            if (fc_start && resp_en) resp_cnt = RESP_DELAY;
        end
    end

    start_t s_exp;
    res_t   r_exp;
    always @(negedge clk) begin
        if (rst) begin
            prev_rv    = 1'b0;
            exp_layers = '0;
        end else begin
            if (fc_start) begin
                n_starts++;
                last_start_cyc = cyc;
                check_eq("start_expected", 32'(start_q.size() != 0), 1);
                if (start_q.size() != 0) begin
                    s_exp = start_q.pop_front();
                    check_eq("fc_input_ptr", fc_input_ptr, s_exp.ip);
                    check_eq("fc_weights_ptr", fc_weights_ptr, s_exp.wp);
                    check_eq("fc_bias_ptr", fc_bias_ptr, s_exp.bp);
                    check_eq("fc_output_ptr", fc_output_ptr, s_exp.op);
                    check_eq("fc_dims", fc_dims, s_exp.dims);
                end
            end
            if (res_valid && !prev_rv) last_rise_cyc = cyc;
            if (res_valid && res_ready) begin
                n_results++;
                check_eq("result_expected", 32'(res_q.size() != 0), 1);
                if (res_q.size() != 0) begin
                    r_exp = res_q.pop_front();
                    check_eq("res_data", res_data, r_exp.data);
                    check_eq("res_error", 32'(res_error), 32'(r_exp.err));
                end
                check_eq("layers_done", 32'(layers_done), 32'(exp_layers));
                exp_layers = exp_layers + 16'd1;
            end
            prev_rv = res_valid;
        end
    end

    task automatic push_desc(input logic [31:0] ip, input logic [31:0] wp,
                             input logic [31:0] bp, input logic [31:0] op,
                             input logic [15:0] isz, input logic [15:0] osz);
        int waited = 0;
        desc_input_ptr   = ip;
        desc_weights_ptr = wp;
        desc_bias_ptr    = bp;
        desc_output_ptr  = op;
        desc_input_size  = isz;
        desc_output_size = osz;
        desc_valid       = 1'b1;
        while (1) begin
            @(negedge clk);
            if (desc_ready || waited >= 300) break;
            waited++;
        end
        check_eq("push_accepted", 32'(desc_ready), 1);
        if (desc_ready) begin
            push_cyc = cyc;
            if (isz != 16'd0 && osz != 16'd0) begin
                start_q.push_back('{ip: ip, wp: wp, bp: bp, op: op, dims: {isz, osz}});
                if (resp_en) res_q.push_back('{data: exp_result(ip), err: 1'b0});
                else         res_q.push_back('{data: 32'h0, err: 1'b1});
            end else begin
                res_q.push_back('{data: 32'h0, err: 1'b1});
            end
        end
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((res_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(res_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t expected end before 200000", $time);
        $fatal(1);
    end

    initial begin
        int p;
        int s0;
        int r0;
        int n;
        bit ok_v;
        bit ok_d;
        bit ok_l;
        bit ok_s;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_desc_ready", 32'(desc_ready), 1);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_fc_start", 32'(fc_start), 0);
        check_eq("rst_fc_dims", fc_dims, 0);
        check_eq("rst_fc_input_ptr", fc_input_ptr, 0);
        check_eq("rst_layers_done", 32'(layers_done), 0);
        check_eq("rst_res_data", res_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single layer
        s0 = n_starts;
        push_desc(32'h100, 32'h200, 32'h300, 32'h400, 16'd16, 16'd4);
        p = push_cyc;
        wait_idle("single_drain");
        check_eq("single_starts", 32'(n_starts - s0), 1);
        check_eq("push_to_start", 32'(last_start_cyc - p), 2);
        check_eq("done_to_valid", 32'(last_rise_cyc - last_start_cyc), 32'(RESP_DELAY + 1));
        check_eq("single_dims_held", fc_dims, 32'h00100004);
        check_eq("single_layers", 32'(layers_done), 1);

        // back-pressure: five descriptors into a four-entry queue
        fc_ready = 1'b0;
        s0 = n_starts;
        for (int i = 0; i < 4; i++)
            push_desc(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i), 32'h3000 + 32'(i),
                      32'h4000 + 32'(i), 16'(i + 1), 16'd2);
        check_eq("full_desc_ready", 32'(desc_ready), 0);
        fork
            push_desc(32'h1040, 32'h2004, 32'h3004, 32'h4004, 16'd5, 16'd2);
            begin
                repeat (4) @(posedge clk);
                #1;
                check_eq("no_start_unready", 32'(n_starts - s0), 0);
                fc_ready = 1'b1;
            end
        join
        wait_idle("bp_drain");
        check_eq("bp_starts", 32'(n_starts - s0), 5);
        check_eq("bp_layers", 32'(layers_done), 6);

        // zero-size descriptor, then a normal one
        s0 = n_starts;
        push_desc(32'h2000, 32'h2100, 32'h2200, 32'h2300, 16'd0, 16'd8);
        p = push_cyc;
        wait_idle("zero_drain");
        check_eq("zero_no_start", 32'(n_starts - s0), 0);
        check_eq("zero_latency", 32'(last_rise_cyc - p), 2);
        push_desc(32'h2400, 32'h2500, 32'h2600, 32'h2700, 16'd3, 16'd3);
        wait_idle("after_zero_drain");
        check_eq("after_zero_starts", 32'(n_starts - s0), 1);

        // timeout, then a stray done
        resp_en = 1'b0;
        push_desc(32'h3000, 32'h3100, 32'h3200, 32'h3300, 16'd8, 16'd8);
        wait_idle("tmo_drain");
        check_eq("tmo_latency", 32'(last_rise_cyc - last_start_cyc), 32'(TMO + 1));
        r0 = n_results;
        done_inject = 1'b1;
        @(posedge clk);
        #1;
        done_inject = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("late_done_ignored", 32'(n_results - r0), 0);
        check_eq("late_done_busy", 32'(busy), 0);
        resp_en = 1'b1;

        // result stall
        res_ready = 1'b0;
        s0 = n_starts;
        push_desc(32'h4000, 32'h4100, 32'h4200, 32'h4300, 16'd2, 16'd2);
        push_desc(32'h5000, 32'h5100, 32'h5200, 32'h5300, 16'd2, 16'd2);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("stall_valid_seen", 32'(res_valid), 1);
        ok_v = 1'b1; ok_d = 1'b1; ok_l = 1'b1; ok_s = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            ok_v &= (res_valid === 1'b1);
            ok_d &= (res_data === exp_result(32'h4000));
            ok_l &= (layers_done === exp_layers);
            ok_s &= (n_starts == s0 + 1);
        end
        check_eq("stall_valid_stable", 32'(ok_v), 1);
        check_eq("stall_data_stable", 32'(ok_d), 1);
        check_eq("stall_layers_held", 32'(ok_l), 1);
        check_eq("stall_no_new_start", 32'(ok_s), 1);
        res_ready = 1'b1;
        wait_idle("stall_drain");
        check_eq("stall_starts", 32'(n_starts - s0), 2);

        // asynchronous reset while waiting for done
        resp_en = 1'b0;
        s0 = n_starts;
        push_desc(32'h6000, 32'h6100, 32'h6200, 32'h6300, 16'd4, 16'd4);
        push_desc(32'h7000, 32'h7100, 32'h7200, 32'h7300, 16'd4, 16'd4);
        n = 0;
        while (n_starts == s0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rst_test_started", 32'(n_starts - s0), 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_fc_start", 32'(fc_start), 0);
        check_eq("async_fc_input_ptr", fc_input_ptr, 0);
        check_eq("async_fc_dims", fc_dims, 0);
        check_eq("async_res_valid", 32'(res_valid), 0);
        check_eq("async_busy", 32'(busy), 0);
        check_eq("async_desc_ready", 32'(desc_ready), 1);
        check_eq("async_layers_done", 32'(layers_done), 0);
        res_q.delete();
        start_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_en = 1'b1;
        s0 = n_starts;
        r0 = n_results;
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_no_result", 32'(n_results - r0), 0);
        check_eq("post_rst_no_start", 32'(n_starts - s0), 0);
        check_eq("post_rst_idle", 32'(busy), 0);

        push_desc(32'h8000, 32'h8100, 32'h8200, 32'h8300, 16'd1, 16'd1);
        wait_idle("post_rst_drain");
        check_eq("post_rst_layers", 32'(layers_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Command-side initiator for `fully_connected_unit`. Accepts fully-connected layer descriptors into a small queue and issues them one at a time over the unit's start/ready/done handshake: it drives pointers and packed dims, pulses start, waits for done and returns the captured result. It sits between the softcore's layer scheduler and the FC unit. It adds back-pressure, a timeout watchdog and rejection of zero-size layers.

## Interface
- `DEPTH`, 4: descriptor FIFO entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 65535: max cycles from start pulse to done before abort
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `desc_valid` in 1 / `desc_ready` out 1: descriptor push handshake
- `desc_input_ptr`, `desc_weights_ptr`, `desc_bias_ptr`, `desc_output_ptr` in 32 each: layer pointers
- `desc_input_size`, `desc_output_size` in 16 each: layer dimensions
- `fc_start` out 1: one-cycle start pulse to the unit
- `fc_input_ptr`, `fc_weights_ptr`, `fc_bias_ptr`, `fc_output_ptr` out 32 each: registered pointers
- `fc_dims` out 32: {input_size[31:16], output_size[15:0]}
- `fc_ready` in 1, `fc_done` in 1, `fc_result` in 32: from the unit
- `res_valid` out 1 / `res_ready` in 1: result handshake
- `res_data` out 32, `res_error` out 1: result word; error flag (timeout or zero-size)
- `busy` out 1: FIFO non-empty or state ≠ IDLE
- `layers_done` out 16: count of emitted results, wraps at 0xFFFF→0

## Operation
- FIFO stores {4 pointers, 2 sizes} = 160 bits. `desc_ready` = !full. Push and pop in the same cycle are allowed; when full, a push is accepted only if a pop happens in that cycle.
- FSM states: IDLE, ISSUE, WAIT_DONE, EMIT.
- IDLE: if the FIFO is non-empty, latch the head into the `fc_*` registers.
  - If either size is 0, go to EMIT with `res_error`=1 and `res_data`=0. No start is issued.
  - Otherwise, if `fc_ready`=1, go to ISSUE. If `fc_ready`=0, wait in IDLE.
- ISSUE: `fc_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_DONE.
- WAIT_DONE: on `fc_done`=1, capture `fc_result` into `res_data`, set `res_error`=0 and go to EMIT. If the counter reaches TIMEOUT_CYCLES first, set `res_data`=0 and `res_error`=1 and go to EMIT. `fc_done` wins when it coincides with the timeout.
- EMIT: hold `res_valid`=1 and the data stable until `res_ready`. On the handshake: pop the FIFO, increment `layers_done`, return to IDLE.
- `fc_done` outside WAIT_DONE is ignored.
- `fc_*` pointer/dims outputs stay stable from latch until the next latch. The unit samples dims while in its own IDLE.

## Timing
- Reset values: all `fc_*` outputs 0, `fc_start` 0, `desc_ready` 1, `res_valid` 0, `res_data` 0, `res_error` 0, `busy` 0, `layers_done` 0, FIFO empty, state IDLE.
- Asserting `rst` mid-operation aborts immediately: the FIFO is flushed and no result is emitted for the in-flight layer.
- Push-to-start latency: descriptor accepted at cycle T → state ISSUE and `fc_start`=1 at T+2, given an empty FIFO, IDLE state and `fc_ready`=1.
- `fc_done` at cycle D → `res_valid`=1 at D+1.
- `res_ready` held at 1 → the next start can occur 2 cycles after the result handshake.
- Zero-size descriptor: head visible at T+1 → `res_valid` at T+2.
- Timeout: ISSUE at cycle S with no done → `res_valid` with `res_error` at S+TIMEOUT_CYCLES+1.

## Structure
- Package `fc_seq_pkg`:
  - state enum
  - descriptor struct/width constant `FC_DESC_W`=160
  - `FC_DIMS_IN_MSB`/`LSB` field positions for dims packing
- Sub-module `fc_desc_fifo`: synchronous FIFO, parameter `DEPTH`, with full/empty/count and pointers that wrap.
- Sequencer FSM, timeout counter and result register live in the top level.

## Test plan
- Single layer: push ptrs 0x100/0x200/0x300/0x400, sizes 16/4. The responder model asserts done 10 cycles after start with result 0xDEADBEEF.
  - Expect `fc_dims`=0x00100004 and one `fc_start` at T+2.
  - Expect `res_data`=0xDEADBEEF, `res_error`=0, `layers_done`=1.
- Back-pressure: push 5 descriptors with DEPTH=4 and `fc_ready` held at 0.
  - `desc_ready` drops after the 4th push.
  - Releasing `fc_ready` drains all 5 layers in order, with 5 results and exactly 5 start pulses.
- Zero-size: push input_size=0, output_size=8 → no `fc_start`, `res_error`=1, `res_data`=0. The next valid descriptor still issues.
- Timeout: TIMEOUT_CYCLES=20 and the responder never asserts done → `res_error`=1 at S+21. A late `fc_done` afterwards is ignored.
- Result stall: hold `res_ready`=0 for 50 cycles → `res_valid`/`res_data` remain stable, no new start, `layers_done` unchanged until the handshake.
- Reset mid-WAIT_DONE: assert `rst` asynchronously between clock edges → all outputs are at reset values immediately, the FIFO is empty, and no result appears after release.
